// File: rtl/tl_sensor_cond.sv
// Vehicle-detector conditioner for the 4-phase left-turn light controller.
// Per channel: 2-FF sync, debounce, hold extension, and a cross-channel starvation guard.
module tl_sensor_cond #(
  parameter int unsigned DEB_CYCLES   = 4,
  parameter int unsigned HOLD_CYCLES  = 8,
  parameter int unsigned MAX_HIGH     = 64,
  parameter int unsigned YIELD_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       raw_a,
  input  logic       raw_b,
  input  logic       raw_al,
  input  logic       raw_bl,
  output logic       Ta,
  output logic       Tb,
  output logic       Tal,
  output logic       Tbl,
  output logic [3:0] yield
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam int unsigned CW = (MAX_HIGH > 0) ? $clog2(MAX_HIGH + 1) : 1;
  localparam int unsigned YW = $clog2(YIELD_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LD  = HW'(HOLD_CYCLES);
  localparam logic [CW-1:0] CONT_MAX = CW'(MAX_HIGH);
  localparam logic [YW-1:0] YLD_LD   = YW'(YIELD_CYCLES);

  logic [3:0]    w_raw;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_deb;
  logic [3:0]    r_yield;
  logic [3:0]    r_t;
  logic [DW-1:0] r_deb_cnt  [4];
  logic [HW-1:0] r_hold_cnt [4];
  logic [CW-1:0] r_cont_cnt [4];
  logic [YW-1:0] r_y_cnt    [4];

  logic [3:0]    w_req;
  logic [3:0]    w_active;
  logic [3:0]    w_elig;
  logic [3:0]    w_trig;

  assign w_raw = {raw_bl, raw_al, raw_b, raw_a};

  always_comb begin
    w_req    = '0;
    w_active = '0;
    w_elig   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_req[i] = r_deb[i] | (r_hold_cnt[i] != '0);
    end
    w_active = w_req & ~r_yield;
    for (int unsigned i = 0; i < 4; i++) begin
      w_elig[i] = (MAX_HIGH != 0) && (r_cont_cnt[i] == CONT_MAX) && !r_yield[i] &&
                  ((w_active & ~(4'b0001 << i)) != '0);
    end
  end

  // Isolate the lowest set bit so at most one channel enters yield per edge.
  assign w_trig = w_elig & (~w_elig + 4'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_deb   <= '0;
      r_yield <= '0;
      r_t     <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        r_deb_cnt[i]  <= '0;
        r_hold_cnt[i] <= '0;
        r_cont_cnt[i] <= '0;
        r_y_cnt[i]    <= '0;
      end
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      r_t  <= w_req & ~r_yield;
      for (int unsigned i = 0; i < 4; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == DEB_LAST) begin
          r_deb[i]     <= r_s2[i];
          r_deb_cnt[i] <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + DW'(1);
        end

        if (r_deb[i]) begin
          r_hold_cnt[i] <= HOLD_LD;
        end else if (r_hold_cnt[i] != '0) begin
          r_hold_cnt[i] <= r_hold_cnt[i] - HW'(1);
        end

        // A yielding channel finishes its full window even if its request drops.
        if (r_yield[i]) begin
          r_y_cnt[i] <= r_y_cnt[i] - YW'(1);
          if (r_y_cnt[i] == YW'(1)) begin
            r_yield[i]    <= 1'b0;
            r_cont_cnt[i] <= '0;
          end else if (!w_req[i]) begin
            r_cont_cnt[i] <= '0;
          end
        end else begin
          if (!w_req[i]) begin
            r_cont_cnt[i] <= '0;
          end else if (r_cont_cnt[i] != CONT_MAX) begin
            r_cont_cnt[i] <= r_cont_cnt[i] + CW'(1);
          end
          if (w_trig[i]) begin
            r_yield[i] <= 1'b1;
            r_y_cnt[i] <= YLD_LD;
          end
        end
      end
    end
  end

  assign Ta    = r_t[0];
  assign Tb    = r_t[1];
  assign Tal   = r_t[2];
  assign Tbl   = r_t[3];
  assign yield = r_yield;

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Self-checking bench for tl_sensor_cond: timestamp-based reference model plus
// directed scenarios and a randomized run.
module tb_tl_sensor_cond;

  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int MAXH = 64;
  localparam int YLD  = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       raw_a = 1'b0, raw_b = 1'b0, raw_al = 1'b0, raw_bl = 1'b0;
  logic       Ta, Tb, Tal, Tbl;
  logic [3:0] yield;

  tl_sensor_cond #(
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .MAX_HIGH    (MAXH),
    .YIELD_CYCLES(YLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .raw_a (raw_a),
    .raw_b (raw_b),
    .raw_al(raw_al),
    .raw_bl(raw_bl),
    .Ta    (Ta),
    .Tb    (Tb),
    .Tal   (Tal),
    .Tbl   (Tbl),
    .yield (yield)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int t = 0;

  // Reference model: the debounced level, the edge at which the debounced level was last
  // seen high (hold window), a continuous-high count, and the edge at which a yield ends.
  bit [3:0] m_s1, m_s2, m_deb, m_req, m_y, m_T;
  int       m_run[4], m_last_hi[4], m_cont[4], m_yend[4];
  logic [7:0] obs, expv;

  task automatic model_clear();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_req = '0; m_y = '0; m_T = '0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0; m_last_hi[i] = -1; m_cont[i] = 0; m_yend[i] = 0;
    end
  endtask

  task automatic tick(input bit rst, input bit [3:0] raw);
    bit [3:0] req_pre, y_pre, s2_pre;
    bit       other, taken;
    int       cont_pre;
    reset  = rst;
    raw_a  = raw[0];
    raw_b  = raw[1];
    raw_al = raw[2];
    raw_bl = raw[3];
    @(posedge clk);
    t++;
    if (rst) begin
      model_clear();
    end else begin
      req_pre = m_req;
      y_pre   = m_y;
      s2_pre  = m_s2;
      m_T     = req_pre & ~y_pre;
      m_s2    = m_s1;
      m_s1    = raw;
      taken   = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (m_deb[i]) m_last_hi[i] = t;
        if (s2_pre[i] == m_deb[i]) begin
          m_run[i] = 0;
        end else begin
          m_run[i]++;
          if (m_run[i] >= DEB) begin
            m_deb[i] = s2_pre[i];
            m_run[i] = 0;
          end
        end
        m_req[i] = m_deb[i] || (m_last_hi[i] >= 0 && (t - m_last_hi[i]) < HOLD);

        cont_pre = m_cont[i];
        other = 1'b0;
        for (int j = 0; j < 4; j++)
          if (j != i && req_pre[j] && !y_pre[j]) other = 1'b1;
        if (y_pre[i]) begin
          if (t == m_yend[i]) begin
            m_y[i] = 1'b0;
            m_cont[i] = 0;
          end else if (!req_pre[i]) begin
            m_cont[i] = 0;
          end
        end else begin
          if (!req_pre[i]) m_cont[i] = 0;
          else if (m_cont[i] < MAXH) m_cont[i]++;
          if (MAXH > 0 && cont_pre == MAXH && other && !taken) begin
            m_y[i] = 1'b1;
            m_yend[i] = t + YLD;
            taken = 1'b1;
          end
        end
      end
    end
    #1;
    obs  = {yield, Tbl, Tal, Tb, Ta};
    expv = {m_y, m_T};
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      tick(1'b1, 4'hF);
      checks++;
      if (obs !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold t=%0d got=%b exp=%b", t, obs, 8'h00);
      end
    end
    for (int c = 1; c <= 8; c++) begin
      tick(1'b0, 4'hF);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL reset_model t=%0d got=%b exp=%b", t, obs, expv);
      end
      checks++;
      if (Ta !== (c >= 7)) begin
        failures++;
        $display("FAIL reset_latency edge=%0d got Ta=%b exp=%b", c, Ta, (c >= 7));
      end
    end
  endtask

  task automatic test_bounce();
    int pat[5] = '{1, 0, 1, 1, 0};
    bit v;
    bit rose;
    tick(1'b1, 4'h0);
    for (int k = 0; k < 25; k++) begin
      v = (k < 5) ? pat[k][0] : 1'b0;
      tick(1'b0, {3'b000, v});
      checks++;
      if (obs !== expv || Ta !== 1'b0) begin
        failures++;
        $display("FAIL bounce_glitch t=%0d got=%b exp=%b", t, obs, expv);
      end
    end
    for (int k = 0; k < 23; k++) begin
      tick(1'b0, {3'b000, k < 3});
      checks++;
      if (obs !== expv || Ta !== 1'b0) begin
        failures++;
        $display("FAIL bounce_short t=%0d got=%b exp=%b", t, obs, expv);
      end
    end
    rose = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick(1'b0, {3'b000, k < 6});
      if (Ta === 1'b1) rose = 1'b1;
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL bounce_long t=%0d got=%b exp=%b", t, obs, expv);
      end
    end
    checks++;
    if (rose !== 1'b1) begin
      failures++;
      $display("FAIL bounce_rise got rose=%b exp=1", rose);
    end
  endtask

  task automatic test_hold();
    int  t_low, t_fall, rises, falls;
    bit  prev;
    tick(1'b1, 4'h0);
    t_low = -1; t_fall = -1; prev = 1'b0;
    for (int k = 0; k < 50; k++) begin
      tick(1'b0, {2'b00, k < 20, 1'b0});
      if (k == 20) t_low = t;
      if (prev && !Tb && t_fall < 0) t_fall = t;
      prev = Tb;
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL hold_model t=%0d got=%b exp=%b", t, obs, expv);
      end
    end
    checks++;
    if (t_fall - t_low !== 14) begin
      failures++;
      $display("FAIL hold_latency got=%0d exp=14", t_fall - t_low);
    end
    rises = 0; falls = 0; prev = Tb;
    for (int k = 0; k < 80; k++) begin
      tick(1'b0, {2'b00, (k < 20) || (k >= 26 && k < 36), 1'b0});
      if (!prev && Tb) rises++;
      if (prev && !Tb) falls++;
      prev = Tb;
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL hold_redetect_model t=%0d got=%b exp=%b", t, obs, expv);
      end
    end
    checks++;
    if (rises !== 1 || falls !== 1) begin
      failures++;
      $display("FAIL hold_continuous got rises=%0d falls=%0d exp 1/1", rises, falls);
    end
  endtask

  task automatic test_starvation();
    int  y0_len, y0_eps, ta_low;
    bit  prev_y0, seen_ta;
    tick(1'b1, 4'h0);
    y0_len = 0; y0_eps = 0; ta_low = 0; prev_y0 = 1'b0; seen_ta = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick(1'b0, {c >= 100, 2'b00, 1'b1});
      if (yield[0] && !prev_y0) y0_eps++;
      if (yield[0] && y0_eps == 1) y0_len++;
      if (Ta) seen_ta = 1'b1;
      if (seen_ta && !Ta && y0_eps == 1) ta_low++;
      prev_y0 = yield[0];
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL starve_model t=%0d got=%b exp=%b", t, obs, expv);
      end
      if (yield[0] === 1'b1) begin
        checks++;
        if (Tbl !== 1'b1 || yield[2:1] !== 2'b00) begin
          failures++;
          $display("FAIL starve_others t=%0d got Tbl=%b yield=%b exp Tbl=1 yield[2:1]=00", t, Tbl, yield);
        end
      end
    end
    checks++;
    if (y0_len !== YLD || ta_low !== YLD) begin
      failures++;
      $display("FAIL starve_window got yield_len=%0d ta_low=%0d exp=%0d", y0_len, ta_low, YLD);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] first_y;
    bit         seen_y1;
    tick(1'b1, 4'h0);
    first_y = 4'h0; seen_y1 = 1'b0;
    for (int c = 0; c < 250; c++) begin
      tick(1'b0, 4'b0011);
      if (first_y == 4'h0 && yield != 4'h0) first_y = yield;
      if (yield[1]) seen_y1 = 1'b1;
      checks++;
      if (obs !== expv || yield === 4'b0011) begin
        failures++;
        $display("FAIL simul_model t=%0d got=%b exp=%b", t, obs, expv);
      end
    end
    checks++;
    if (first_y !== 4'b0001 || seen_y1 !== 1'b1) begin
      failures++;
      $display("FAIL simul_order got first=%b y1=%b exp first=0001 y1=1", first_y, seen_y1);
    end
  endtask

  task automatic test_reset_mid_yield();
    bit found;
    tick(1'b1, 4'h0);
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      tick(1'b0, 4'b0101);
      if (yield[2] === 1'b1) found = 1'b1;
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL midyield_model t=%0d got=%b exp=%b", t, obs, expv);
      end
    end
    checks++;
    if (found !== 1'b1) begin
      failures++;
      $display("FAIL midyield_timeout got yield2=0 exp=1 within 400 cycles");
    end
    tick(1'b1, 4'b0101);
    checks++;
    if (obs !== 8'h00) begin
      failures++;
      $display("FAIL midyield_reset t=%0d got=%b exp=%b", t, obs, 8'h00);
    end
    for (int c = 1; c <= 8; c++) begin
      tick(1'b0, 4'b0001);
      checks++;
      if (obs !== expv || Ta !== (c >= 7)) begin
        failures++;
        $display("FAIL midyield_relatch edge=%0d got=%b exp=%b", c, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    bit [3:0] raw;
    bit       rst;
    int       span;
    raw = '0;
    tick(1'b1, raw);
    for (int c = 0; c < 900; c++) begin
      span = (c < 300) ? 3 : 60;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, span) == 0) raw[i] = ~raw[i];
      rst = ($urandom_range(0, 349) == 0);
      tick(rst, raw);
      checks++;
      if (obs !== expv) begin
        failures++;
        $display("FAIL random_model t=%0d got=%b exp=%b", t, obs, expv);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_bounce();
    test_hold();
    test_starvation();
    test_simultaneous();
    test_reset_mid_yield();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
